// File: rtl/hazard_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit_pkg
// Shared encodings for the ID-stage hazard control slice: MIPS opcodes and
// function codes that cause a fetch redirect, the REGIMM rt-field codes for
// BGEZ/BLTZ, and the load-use stall FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_ctrl_unit_pkg;

   localparam logic [5:0] OP_R_type     = 6'b000000;
   localparam logic [5:0] OP_BGEZ_BLTZ  = 6'b000001;
   localparam logic [5:0] OP_J_type     = 6'b000010;
   localparam logic [5:0] OP_JAL_type   = 6'b000011;
   localparam logic [5:0] OP_BEQ_type   = 6'b000100;
   localparam logic [5:0] OP_BNE_type   = 6'b000101;
   localparam logic [5:0] OP_BLEZ_type  = 6'b000110;
   localparam logic [5:0] OP_BGTZ_type  = 6'b000111;

   // REGIMM rt-field values, carried in the low 5 bits of the funct field
   localparam logic [4:0] ACRON_BLTZ    = 5'b00000;
   localparam logic [4:0] ACRON_BGEZ    = 5'b00001;

   localparam logic [5:0] FUNCT_JR      = 6'b001000;
   localparam logic [5:0] FUNCT_JALR    = 6'b001001;

   typedef enum logic {
      LD_IDLE = 1'b0,
      LD_WAIT = 1'b1
   } ld_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit_if
// Bundle between the ID/EX pipeline datapath and the hazard control unit.
//   master : pipeline side, drives ID/EX instruction info, receives controls
//   slave  : hazard unit side
// Signals:
//   id_op/id_funct      ID opcode / funct (REGIMM rt in funct[4:0])
//   id_rs/id_rt         ID source registers, with *_used qualifiers
//   id_bresult          branch condition resolved true in ID
//   id_mdu_use          ID instruction touches HI/LO or the MDU
//   ex_rw/ex_mem_read   EX destination register / EX is a load
//   mdu_start           one-cycle pulse as an MDU op enters EX
//   pc_if_wr            PC + IF/ID write enable
//   id_ex_bubble        insert NOP into ID/EX
//   if_id_flush_n       active-low IF/ID flush
//   stall_cnt/flush_cnt performance counters
// -----------------------------------------------------------------------------
interface hazard_ctrl_unit_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);

   logic [5:0]        id_op;
   logic [5:0]        id_funct;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_rs_used;
   logic              id_rt_used;
   logic              id_bresult;
   logic              id_mdu_use;
   logic [REG_AW-1:0] ex_rw;
   logic              ex_mem_read;
   logic              mdu_start;
   logic              pc_if_wr;
   logic              id_ex_bubble;
   logic              if_id_flush_n;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_op, id_funct, id_rs, id_rt, id_rs_used, id_rt_used,
             id_bresult, id_mdu_use, ex_rw, ex_mem_read, mdu_start,
      input  pc_if_wr, id_ex_bubble, if_id_flush_n, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_op, id_funct, id_rs, id_rt, id_rs_used, id_rt_used,
             id_bresult, id_mdu_use, ex_rw, ex_mem_read, mdu_start,
      output pc_if_wr, id_ex_bubble, if_id_flush_n, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_ctrl_unit_redirect.sv
// -----------------------------------------------------------------------------
// redirect_decode
// Purely combinational: flags an ID instruction that redirects fetch, i.e. a
// taken BEQ/BNE/BGTZ/BLEZ/BGEZ/BLTZ or any J/JAL/JR/JALR.
// Ports:
//   op       in  6  opcode
//   funct    in  6  funct (REGIMM rt field in funct[4:0])
//   bresult  in  1  branch condition true
//   redirect out 1  instruction changes the fetch stream
// -----------------------------------------------------------------------------
module redirect_decode
   import hazard_ctrl_unit_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       bresult,
   output logic       redirect
);

   // REGIMM shares one opcode among several branches; only BGEZ/BLTZ are
   // recognised, the linking variants fall through as non-redirecting.
   always_comb begin
      redirect = 1'b0;
      case (op)
         OP_BEQ_type, OP_BNE_type, OP_BGTZ_type, OP_BLEZ_type:
            redirect = bresult;
         OP_BGEZ_BLTZ:
            redirect = bresult & ((funct[4:0] == ACRON_BGEZ) |
                                  (funct[4:0] == ACRON_BLTZ));
         OP_J_type, OP_JAL_type:
            redirect = 1'b1;
         OP_R_type:
            redirect = (funct == FUNCT_JR) | (funct == FUNCT_JALR);
         default:
            redirect = 1'b0;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// ID-stage hazard control for the 5-stage pipeline. Detects load-use hazards
// (multi-cycle stall for LOAD_LAT cycles), MDU busy interlock and branch/jump
// redirects, and drives the PC/IF-ID write enable, the ID/EX bubble and the
// IF/ID flush. A stall always wins over a flush.
// Ports:
//   clk  in  pipeline clock
//   rst  in  asynchronous active-low reset
//   hz   hazard_ctrl_unit_if.slave (ID/EX info in, pipeline controls out)
// Optional build macro HAZARD_PERF_CNT_EN: saturating stall/flush counters on
// hz.stall_cnt / hz.flush_cnt; without it both are tied to zero.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int MDU_LAT  = 32,
   parameter int CNT_W    = 32
)(
   input  logic               clk,
   input  logic               rst,
   hazard_ctrl_unit_if.slave  hz
);

   ld_state_e         ld_state, ld_state_nxt;
   logic [2:0]        ld_cnt, ld_cnt_nxt;
   logic [5:0]        mdu_cnt;
   logic [REG_AW-1:0] id_rs, id_rt, ex_rw;
   logic              ld_hit, ld_stall;
   logic              mdu_busy, mdu_stall;
   logic              stall, redirect, flush;

   assign id_rs = hz.id_rs;
   assign id_rt = hz.id_rt;
   assign ex_rw = hz.ex_rw;

   // $0 is hard-wired zero, so a load targeting it can never create a hazard
   assign ld_hit = hz.ex_mem_read & (ex_rw != '0) &
                   ((hz.id_rs_used & (id_rs == ex_rw)) |
                    (hz.id_rt_used & (id_rt == ex_rw)));

   // Load-use FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_state <= LD_IDLE;
         ld_cnt   <= '0;
      end else begin
         ld_state <= ld_state_nxt;
         ld_cnt   <= ld_cnt_nxt;
      end
   end

   // The hit cycle itself is the first stall cycle; LD_WAIT covers the
   // remaining LOAD_LAT-1. New hits are ignored in LD_WAIT because EX then
   // holds the bubble we inserted.
   always_comb begin
      ld_state_nxt = ld_state;
      ld_cnt_nxt   = ld_cnt;
      ld_stall     = 1'b0;
      case (ld_state)
         LD_IDLE: begin
            if (ld_hit) begin
               ld_stall = 1'b1;
               if (LOAD_LAT > 1) begin
                  ld_state_nxt = LD_WAIT;
                  ld_cnt_nxt   = 3'(LOAD_LAT - 1);
               end
            end
         end
         LD_WAIT: begin
            ld_stall   = 1'b1;
            ld_cnt_nxt = ld_cnt - 3'd1;
            if (ld_cnt == 3'd1) begin
               ld_state_nxt = LD_IDLE;
            end
         end
         default: ld_state_nxt = LD_IDLE;
      endcase
   end

   // MDU busy countdown; a new start while busy simply reloads the count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mdu_cnt <= '0;
      end else if (hz.mdu_start) begin
         mdu_cnt <= 6'(MDU_LAT);
      end else if (mdu_cnt != '0) begin
         mdu_cnt <= mdu_cnt - 6'd1;
      end
   end

   assign mdu_busy  = hz.mdu_start | (mdu_cnt != '0);
   assign mdu_stall = mdu_busy & hz.id_mdu_use;

   redirect_decode u_redirect (
      .op       (hz.id_op),
      .funct    (hz.id_funct),
      .bresult  (hz.id_bresult),
      .redirect (redirect)
   );

   // Reset is folded in combinationally so the controls are forced to their
   // idle values the instant rst falls, even with hazard inputs present.
   assign stall = rst & (ld_stall | mdu_stall);
   assign flush = rst & redirect & ~stall;

   assign hz.pc_if_wr      = ~stall;
   assign hz.id_ex_bubble  = stall;
   assign hz.if_id_flush_n = ~flush;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   // Saturating performance counters, one count per stalled / flushed cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`else
   assign hz.stall_cnt = {CNT_W{1'b0}};
   assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Drives identical ID/EX traffic into two hazard_ctrl_unit instances
// (dut_a: LOAD_LAT=1, CNT_W=32; dut_b: LOAD_LAT=3, CNT_W=2; both MDU_LAT=4)
// and checks them every cycle against a cycle-level behavioural model, with
// hand-computed literal expectations at key points of the directed sequence.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

   localparam int MDU_LAT = 4;

   typedef enum int {
      K_NOP, K_ADD, K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_BGEZ, K_BLTZ, K_BLTZAL,
      K_J, K_JAL, K_JR, K_JALR, K_MFLO, K_MULT
   } kind_e;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] id_op = '0;
   logic [5:0] id_funct = '0;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic       id_rs_used = 1'b0;
   logic       id_rt_used = 1'b0;
   logic       id_bresult = 1'b0;
   logic       id_mdu_use = 1'b0;
   logic [4:0] ex_rw = '0;
   logic       ex_mem_read = 1'b0;
   logic       mdu_start = 1'b0;
   kind_e      cur_kind = K_NOP;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(32)) if_a ();
   hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(2))  if_b ();

   assign if_a.id_op = id_op;             assign if_b.id_op = id_op;
   assign if_a.id_funct = id_funct;       assign if_b.id_funct = id_funct;
   assign if_a.id_rs = id_rs;             assign if_b.id_rs = id_rs;
   assign if_a.id_rt = id_rt;             assign if_b.id_rt = id_rt;
   assign if_a.id_rs_used = id_rs_used;   assign if_b.id_rs_used = id_rs_used;
   assign if_a.id_rt_used = id_rt_used;   assign if_b.id_rt_used = id_rt_used;
   assign if_a.id_bresult = id_bresult;   assign if_b.id_bresult = id_bresult;
   assign if_a.id_mdu_use = id_mdu_use;   assign if_b.id_mdu_use = id_mdu_use;
   assign if_a.ex_rw = ex_rw;             assign if_b.ex_rw = ex_rw;
   assign if_a.ex_mem_read = ex_mem_read; assign if_b.ex_mem_read = ex_mem_read;
   assign if_a.mdu_start = mdu_start;     assign if_b.mdu_start = mdu_start;

   hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .MDU_LAT(MDU_LAT), .CNT_W(32)) dut_a (
      .clk (clk),
      .rst (rst),
      .hz  (if_a)
   );

   hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .MDU_LAT(MDU_LAT), .CNT_W(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .hz  (if_b)
   );

   task automatic checkOutput(input string name, input longint unsigned act,
                              input longint unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkAll(input int d, input string tag, input bit pc,
                           input bit bub, input bit fl);
      checkOutput({tag, "_pc_if_wr"},      (d == 0) ? if_a.pc_if_wr      : if_b.pc_if_wr,      pc);
      checkOutput({tag, "_id_ex_bubble"},  (d == 0) ? if_a.id_ex_bubble  : if_b.id_ex_bubble,  bub);
      checkOutput({tag, "_if_id_flush_n"}, (d == 0) ? if_a.if_id_flush_n : if_b.if_id_flush_n, fl);
   endtask

   // Redirect rule in mnemonic terms
   function automatic bit redirectOf(input kind_e k, input bit bres);
      case (k)
         K_BEQ, K_BNE, K_BLEZ, K_BGTZ, K_BGEZ, K_BLTZ: return bres;
         K_J, K_JAL, K_JR, K_JALR:                     return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

   // Inputs change 1 time unit after the rising edge; checks happen 4 later
   task automatic applyStimulus(input kind_e k, input int rs, input int rt,
                                input bit bres, input bit ld, input int rw,
                                input bit ms, input bit rv = 1'b1);
      @(posedge clk);
      #1;
      rst         = rv;
      cur_kind    = k;
      id_rs       = 5'(rs);
      id_rt       = 5'(rt);
      id_bresult  = bres;
      ex_mem_read = ld;
      ex_rw       = 5'(rw);
      mdu_start   = ms;
      id_op       = 6'h00;
      id_funct    = 6'h00;
      id_rs_used  = 1'b0;
      id_rt_used  = 1'b0;
      id_mdu_use  = 1'b0;
      case (k)
         K_ADD:    begin id_funct = 6'h20; id_rs_used = 1'b1; id_rt_used = 1'b1; end
         K_BEQ:    begin id_op = 6'h04; id_rs_used = 1'b1; id_rt_used = 1'b1; end
         K_BNE:    begin id_op = 6'h05; id_rs_used = 1'b1; id_rt_used = 1'b1; end
         K_BLEZ:   begin id_op = 6'h06; id_rs_used = 1'b1; end
         K_BGTZ:   begin id_op = 6'h07; id_rs_used = 1'b1; end
         K_BGEZ:   begin id_op = 6'h01; id_funct = 6'h01; id_rs_used = 1'b1; end
         K_BLTZ:   begin id_op = 6'h01; id_funct = 6'h00; id_rs_used = 1'b1; end
         K_BLTZAL: begin id_op = 6'h01; id_funct = 6'h10; id_rs_used = 1'b1; end
         K_J:      begin id_op = 6'h02; end
         K_JAL:    begin id_op = 6'h03; end
         K_JR:     begin id_funct = 6'h08; id_rs_used = 1'b1; end
         K_JALR:   begin id_funct = 6'h09; id_rs_used = 1'b1; end
         K_MFLO:   begin id_funct = 6'h12; id_mdu_use = 1'b1; end
         K_MULT:   begin id_funct = 6'h18; id_rs_used = 1'b1; id_rt_used = 1'b1; id_mdu_use = 1'b1; end
         default:  ;
      endcase
      #3;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   // Behavioural model: remaining load-stall cycles per DUT, cycle of the
   // last MDU start, and running stall/flush totals for the counters.
   int              lat [2] = '{1, 3};
   int              ld_left [2] = '{0, 0};
   longint unsigned stall_tot [2] = '{0, 0};
   longint unsigned flush_tot [2] = '{0, 0};
   longint unsigned cmax [2] = '{64'hFFFF_FFFF, 64'd3};
   int              cyc = 0;
   int              mdu_last = 0;
   bit              mdu_seen = 1'b0;
   bit              hit_e, busy_e, stall_e, flush_e;
   longint unsigned exp_s, exp_f;

   // Every cycle, mid-period: compare both DUTs, then advance the model
   always @(negedge clk) begin
      cyc++;
      hit_e  = ex_mem_read && (ex_rw != '0) &&
               ((id_rs_used && (id_rs == ex_rw)) || (id_rt_used && (id_rt == ex_rw)));
      busy_e = mdu_start ||
               (mdu_seen && ((cyc - mdu_last) >= 1) && ((cyc - mdu_last) <= MDU_LAT));
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            stall_e = 1'b0;
            flush_e = 1'b0;
         end else begin
            stall_e = (ld_left[d] > 0) || hit_e || (busy_e && id_mdu_use);
            flush_e = redirectOf(cur_kind, id_bresult) && !stall_e;
         end
         checkAll(d, $sformatf("model_dut%0d", d), !stall_e, stall_e, !flush_e);
`ifdef HAZARD_PERF_CNT_EN
         exp_s = (stall_tot[d] > cmax[d]) ? cmax[d] : stall_tot[d];
         exp_f = (flush_tot[d] > cmax[d]) ? cmax[d] : flush_tot[d];
`else
         exp_s = 0;
         exp_f = 0;
`endif
         checkOutput($sformatf("model_dut%0d_stall_cnt", d),
                     (d == 0) ? longint'(if_a.stall_cnt) : longint'(if_b.stall_cnt), exp_s);
         checkOutput($sformatf("model_dut%0d_flush_cnt", d),
                     (d == 0) ? longint'(if_a.flush_cnt) : longint'(if_b.flush_cnt), exp_f);
         if (!rst) begin
            ld_left[d]   = 0;
            stall_tot[d] = 0;
            flush_tot[d] = 0;
         end else begin
            if (ld_left[d] > 0)  ld_left[d]--;
            else if (hit_e)      ld_left[d] = lat[d] - 1;
            if (stall_e)         stall_tot[d]++;
            if (flush_e)         flush_tot[d]++;
         end
      end
      if (!rst) begin
         mdu_seen = 1'b0;
      end else if (mdu_start) begin
         mdu_seen = 1'b1;
         mdu_last = cyc;
      end
   end

   kind_e br_kind [15] = '{K_BEQ, K_NOP, K_BEQ, K_JR, K_J, K_JAL, K_JALR, K_BNE,
                           K_BNE, K_BGTZ, K_BLEZ, K_BGEZ, K_BLTZ, K_BLTZAL, K_ADD};
   bit    br_res  [15] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
   bit    br_fl   [15] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};

   initial begin
      $display("[TB] start");

      // Reset, including a load-use pattern that must not leak through
      idleCycles(1);
      applyStimulus(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      checkAll(0, "reset_a", 1'b1, 1'b0, 1'b1);
      applyStimulus(K_ADD, 5, 6, 1'b0, 1'b1, 5, 1'b0, 1'b0);
      checkAll(1, "reset_forced_b", 1'b1, 1'b0, 1'b1);
      idleCycles(1);

      // Load-use: 1 stall on dut_a, 3 on dut_b
      applyStimulus(K_ADD, 5, 6, 1'b0, 1'b1, 5, 1'b0);
      checkAll(0, "ld_hit_a", 1'b0, 1'b1, 1'b1);
      checkAll(1, "ld_hit_b", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_ADD, 5, 6, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "ld_done_a", 1'b1, 1'b0, 1'b1);
      checkAll(1, "ld_wait1_b", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_ADD, 5, 6, 1'b0, 1'b0, 0, 1'b0);
      checkAll(1, "ld_wait2_b", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_ADD, 5, 6, 1'b0, 1'b0, 0, 1'b0);
      checkAll(1, "ld_done_b", 1'b1, 1'b0, 1'b1);

      // $0 destination never hazards; rt match does; unused rs doesn't
      applyStimulus(K_ADD, 0, 6, 1'b0, 1'b1, 0, 1'b0);
      checkAll(0, "ld_r0_a", 1'b1, 1'b0, 1'b1);
      applyStimulus(K_ADD, 1, 7, 1'b0, 1'b1, 7, 1'b0);
      checkAll(0, "ld_rt_a", 1'b0, 1'b1, 1'b1);
      idleCycles(3);
      applyStimulus(K_NOP, 7, 7, 1'b0, 1'b1, 7, 1'b0);
      checkAll(0, "ld_unused_a", 1'b1, 1'b0, 1'b1);

      // Reset in the second stall cycle of dut_b aborts the stall
      applyStimulus(K_ADD, 5, 6, 1'b0, 1'b1, 5, 1'b0);
      checkAll(1, "rst_hit_b", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_ADD, 5, 6, 1'b0, 1'b1, 5, 1'b0, 1'b0);
      checkAll(1, "rst_mid_b", 1'b1, 1'b0, 1'b1);
      applyStimulus(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      checkAll(1, "rst_abort_b", 1'b1, 1'b0, 1'b1);

      // MDU: mflo right after start stalls 4 cycles
      applyStimulus(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      checkAll(0, "mdu_start_a", 1'b1, 1'b0, 1'b1);
      applyStimulus(K_MFLO, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "mdu_st1_a", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_MFLO, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(K_MFLO, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(K_MFLO, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "mdu_st4_a", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_MFLO, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "mdu_free_a", 1'b1, 1'b0, 1'b1);

      // mflo 5 cycles after start: no stall; start+use same cycle: stall
      applyStimulus(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      idleCycles(4);
      applyStimulus(K_MFLO, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "mdu_late_a", 1'b1, 1'b0, 1'b1);
      applyStimulus(K_MULT, 2, 3, 1'b0, 1'b0, 0, 1'b1);
      checkAll(0, "mdu_same_a", 1'b0, 1'b1, 1'b1);
      idleCycles(5);

      // Restart while busy reloads the countdown
      applyStimulus(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      idleCycles(1);
      applyStimulus(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      idleCycles(3);
      applyStimulus(K_MFLO, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "mdu_reload_a", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_MFLO, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "mdu_reload_free_a", 1'b1, 1'b0, 1'b1);

      // Redirect decode table
      for (int i = 0; i < 15; i++) begin
         applyStimulus(br_kind[i], 1, 2, br_res[i], 1'b0, 0, 1'b0);
         checkAll(0, $sformatf("branch%0d_a", i), 1'b1, 1'b0, br_fl[i]);
         checkAll(1, $sformatf("branch%0d_b", i), 1'b1, 1'b0, br_fl[i]);
      end

      // Branch waiting on a load: stall first, redirect on first free cycle
      applyStimulus(K_BEQ, 5, 6, 1'b1, 1'b1, 5, 1'b0);
      checkAll(0, "beq_ld_stall_a", 1'b0, 1'b1, 1'b1);
      checkAll(1, "beq_ld_stall_b", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_BEQ, 5, 6, 1'b1, 1'b0, 0, 1'b0);
      checkAll(0, "beq_ld_redirect_a", 1'b1, 1'b0, 1'b0);
      checkAll(1, "beq_ld_wait_b", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_BEQ, 5, 6, 1'b1, 1'b0, 0, 1'b0);
      applyStimulus(K_BEQ, 5, 6, 1'b1, 1'b0, 0, 1'b0);
      checkAll(1, "beq_ld_redirect_b", 1'b1, 1'b0, 1'b0);
      idleCycles(1);

      // Load hit and MDU interlock together give one merged stall
      applyStimulus(K_NOP, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      applyStimulus(K_MULT, 3, 4, 1'b0, 1'b1, 3, 1'b0);
      checkAll(0, "both_hit_a", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_MULT, 3, 4, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(K_MULT, 3, 4, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(K_MULT, 3, 4, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "both_mdu_tail_a", 1'b0, 1'b1, 1'b1);
      applyStimulus(K_MULT, 3, 4, 1'b0, 1'b0, 0, 1'b0);
      checkAll(0, "both_free_a", 1'b1, 1'b0, 1'b1);
      checkAll(1, "both_free_b", 1'b1, 1'b0, 1'b1);
      idleCycles(2);

`ifdef HAZARD_PERF_CNT_EN
      checkOutput("sat_stall_cnt_b", longint'(if_b.stall_cnt), 3);
      checkOutput("sat_flush_cnt_b", longint'(if_b.flush_cnt), 3);
`endif

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
